sdram_arbit: RTL and testbench

- Arbitrates the single SDRAM command/data bus between four sources: power-up initialisation, auto-refresh, burst write and burst read.
- Sits between the write/read FIFO controller and the SDRAM init/aref/write/read sub-controllers.
- Owns the refresh interval timer and grants one source at a time. Priority order: refresh > write > read.
- Muxes the granted source's command, bank, address and write data onto the SDRAM pins.

---
 rtl/sdram_arbit.sv | 182 ++++++++++++++++++
 tb/tb_sdram_arbit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: owns the refresh interval timer and grants the shared command/data
// bus to one of init, auto-refresh, burst write or burst read (refresh > write > read).
module sdram_arbit #(
    parameter int         CNT_REF_MAX = 780,
    parameter int         DATA_W      = 32,
    parameter logic [3:0] CMD_NOP     = 4'b0111
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [12:0]       init_addr,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [1:0]        aref_ba,
    input  logic [12:0]       aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [12:0]       wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [12:0]       rd_addr,
    output logic              aref_req,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              aref_overrun,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [12:0]       sdram_addr,
    output logic              sdram_dq_oe,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam int             CW       = (CNT_REF_MAX > 1) ? $clog2(CNT_REF_MAX) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_REF_MAX - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CW-1:0]       r_cnt_ref;
    logic                r_aref_req;
    logic                r_aref_overrun;
    logic                r_aref_en;
    logic                r_wr_en;
    logic                r_rd_en;
    logic                w_cnt_wrap;
    logic                w_aref_take;
    logic [3:0]          w_cmd;
    logic [1:0]          w_ba;
    logic [12:0]         w_addr;

    assign w_cnt_wrap  = (r_state != ST_INIT) && (r_cnt_ref == CNT_LAST);
    assign w_aref_take = (r_state == ST_IDLE) && r_aref_req;

    // Bursts always return to IDLE, which gives the one-cycle bus turnaround for free.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT:  if (init_end) w_next_state = ST_IDLE;
            ST_IDLE: begin
                if (r_aref_req)  w_next_state = ST_AREF;
                else if (wr_req) w_next_state = ST_WRITE;
                else if (rd_req) w_next_state = ST_READ;
            end
            ST_AREF:  if (aref_end) w_next_state = ST_IDLE;
            ST_WRITE: if (wr_end)   w_next_state = ST_IDLE;
            ST_READ:  if (rd_end)   w_next_state = ST_IDLE;
            default:  w_next_state = ST_INIT;
        endcase
    end

    // Grants are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_INIT;
            r_aref_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_aref_en <= (w_next_state == ST_AREF);
            r_wr_en   <= (w_next_state == ST_WRITE);
            r_rd_en   <= (w_next_state == ST_READ);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || r_state == ST_INIT) begin
            r_cnt_ref <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt_ref <= '0;
        end else begin
            r_cnt_ref <= r_cnt_ref + CW'(1);
        end
    end

    // A wrap while a refresh is still outstanding marks a missed interval; the request
    // itself stays a single pending flag rather than a count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_aref_req     <= 1'b0;
            r_aref_overrun <= 1'b0;
        end else begin
            if (w_cnt_wrap) begin
                r_aref_req <= 1'b1;
                if (r_aref_req && !w_aref_take) begin
                    r_aref_overrun <= 1'b1;
                end
            end else if (w_aref_take) begin
                r_aref_req <= 1'b0;
            end
        end
    end

    always_comb begin
        w_cmd  = CMD_NOP;
        w_ba   = 2'b11;
        w_addr = 13'h1FFF;
        case (r_state)
            ST_INIT: begin
                w_cmd  = init_cmd;
                w_ba   = init_ba;
                w_addr = init_addr;
            end
            ST_AREF: begin
                w_cmd  = aref_cmd;
                w_ba   = aref_ba;
                w_addr = aref_addr;
            end
            ST_WRITE: begin
                w_cmd  = wr_cmd;
                w_ba   = wr_ba;
                w_addr = wr_addr;
            end
            ST_READ: begin
                w_cmd  = rd_cmd;
                w_ba   = rd_ba;
                w_addr = rd_addr;
            end
            default: begin
                w_cmd  = CMD_NOP;
                w_ba   = 2'b11;
                w_addr = 13'h1FFF;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
    assign sdram_cke    = 1'b1;
    assign sdram_ba     = w_ba;
    assign sdram_addr   = w_addr;
    assign sdram_dq_oe  = (r_state == ST_WRITE) ? wr_sdram_en : 1'b0;
    assign sdram_dq_out = (r_state == ST_WRITE) ? wr_sdram_data : '0;

    assign aref_req     = r_aref_req;
    assign aref_overrun = r_aref_overrun;
    assign aref_en      = r_aref_en;
    assign wr_en        = r_wr_en;
    assign rd_en        = r_rd_en;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: boot, priority, mux, refresh overrun during a long
// write, stray end pulses and reset in the middle of a read.
module tb_sdram_arbit;

    localparam int DATA_W = 32;
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [1:0]        init_ba;
    logic [12:0]       init_addr;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [1:0]        aref_ba;
    logic [12:0]       aref_addr;
    logic              wr_req, wr_end;
    logic [3:0]        wr_cmd;
    logic [1:0]        wr_ba;
    logic [12:0]       wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_sdram_data;
    logic              rd_req, rd_end;
    logic [3:0]        rd_cmd;
    logic [1:0]        rd_ba;
    logic [12:0]       rd_addr;
    logic              aref_req, aref_en, wr_en, rd_en, aref_overrun;
    logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]        sdram_ba;
    logic [12:0]       sdram_addr;
    logic              sdram_dq_oe;
    logic [DATA_W-1:0] sdram_dq_out;
    logic [2:0]        o_dbg_state;

    int n_chk  = 0;
    int n_fail = 0;

    sdram_arbit #(.CNT_REF_MAX(20), .DATA_W(DATA_W), .CMD_NOP(4'b0111)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_req(aref_req), .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .aref_overrun(aref_overrun), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_oe(sdram_dq_oe), .sdram_dq_out(sdram_dq_out), .o_dbg_state(o_dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pins_cmd();
        return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    endfunction

    function automatic logic [2:0] grants();
        return {aref_en, wr_en, rd_en};
    endfunction

    initial begin
        sys_rst = 1'b1;
        init_end = 1'b0; init_cmd = 4'b0010; init_ba = 2'b00; init_addr = 13'h0400;
        aref_end = 1'b0; aref_cmd = 4'b0001; aref_ba = 2'b00; aref_addr = 13'h0001;
        wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'h00A5;
        wr_sdram_en = 1'b0; wr_sdram_data = 32'hDEADBEEF;
        rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 13'h0123;

        // Boot
        tick(2);
        sys_rst = 1'b0;
        chk("rst_state", 32'(o_dbg_state), 32'(S_INIT));
        chk("rst_grants", 32'(grants()), 32'd0);
        chk("rst_aref_req", 32'(aref_req), 32'd0);
        chk("rst_overrun", 32'(aref_overrun), 32'd0);
        chk("init_pins_cmd", 32'(pins_cmd()), 32'h2);
        chk("init_pins_addr", 32'(sdram_addr), 32'h0400);
        chk("cke", 32'(sdram_cke), 32'd1);
        tick(7);
        chk("init_wait_state", 32'(o_dbg_state), 32'(S_INIT));
        init_end = 1'b1;
        tick();
        chk("boot_idle", 32'(o_dbg_state), 32'(S_IDLE));
        chk("idle_cmd_nop", 32'(pins_cmd()), 32'h7);
        chk("idle_ba", 32'(sdram_ba), 32'h3);
        chk("idle_addr", 32'(sdram_addr), 32'h1FFF);
        chk("idle_dq_oe", 32'(sdram_dq_oe), 32'd0);
        // Counter starts at 0 on IDLE entry; wrap lands 20 edges later
        tick(19);
        chk("aref_req_before_wrap", 32'(aref_req), 32'd0);
        tick();
        chk("aref_req_first", 32'(aref_req), 32'd1);
        chk("aref_req_first_state", 32'(o_dbg_state), 32'(S_IDLE));

        // Priority: all three requests pending
        wr_req = 1'b1; rd_req = 1'b1;
        tick();
        chk("prio_aref_state", 32'(o_dbg_state), 32'(S_AREF));
        chk("prio_aref_grant", 32'(grants()), 32'b100);
        chk("aref_req_cleared", 32'(aref_req), 32'd0);
        chk("aref_pins_cmd", 32'(pins_cmd()), 32'h1);
        tick(3);
        chk("aref_hold", 32'(grants()), 32'b100);
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        chk("aref_done_idle", 32'(o_dbg_state), 32'(S_IDLE));
        chk("aref_done_grants", 32'(grants()), 32'd0);
        wr_sdram_en = 1'b1;
        tick();
        chk("prio_write_state", 32'(o_dbg_state), 32'(S_WRITE));
        chk("prio_write_grant", 32'(grants()), 32'b010);

        // Mux in WRITE
        chk("wr_pins_cmd", 32'(pins_cmd()), 32'h4);
        chk("wr_pins_addr", 32'(sdram_addr), 32'h00A5);
        chk("wr_pins_ba", 32'(sdram_ba), 32'h2);
        chk("wr_dq_oe", 32'(sdram_dq_oe), 32'd1);
        chk("wr_dq_out", sdram_dq_out, 32'hDEADBEEF);

        // Stray rd_end during WRITE
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        chk("stray_state", 32'(o_dbg_state), 32'(S_WRITE));
        chk("stray_grant", 32'(grants()), 32'b010);
        wr_end = 1'b1; wr_req = 1'b0;
        tick();
        wr_end = 1'b0;
        chk("wr_done_idle", 32'(o_dbg_state), 32'(S_IDLE));
        chk("wr_done_grants", 32'(grants()), 32'd0);
        tick();
        chk("prio_read_state", 32'(o_dbg_state), 32'(S_READ));
        chk("prio_read_grant", 32'(grants()), 32'b001);
        chk("rd_pins_cmd", 32'(pins_cmd()), 32'h5);
        chk("rd_pins_addr", 32'(sdram_addr), 32'h0123);
        chk("rd_dq_oe", 32'(sdram_dq_oe), 32'd0);
        chk("rd_dq_out", sdram_dq_out, 32'd0);
        rd_end = 1'b1; rd_req = 1'b0;
        tick();
        rd_end = 1'b0;
        chk("rd_done_idle", 32'(o_dbg_state), 32'(S_IDLE));
        chk("no_aref_yet", 32'(aref_req), 32'd0);

        // Long write with refresh timer wrapping twice inside it
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0; rd_req = 1'b1;
        chk("long_wr_state", 32'(o_dbg_state), 32'(S_WRITE));
        tick(8);
        chk("long_wr_pre_wrap", 32'(aref_req), 32'd0);
        tick();
        chk("long_wr_wrap1_req", 32'(aref_req), 32'd1);
        chk("long_wr_wrap1_ovr", 32'(aref_overrun), 32'd0);
        chk("no_preempt_state", 32'(o_dbg_state), 32'(S_WRITE));
        tick(19);
        chk("long_wr_pre_wrap2_ovr", 32'(aref_overrun), 32'd0);
        tick();
        chk("long_wr_wrap2_ovr", 32'(aref_overrun), 32'd1);
        chk("long_wr_wrap2_req", 32'(aref_req), 32'd1);
        tick(250);
        chk("long_wr_hold_state", 32'(o_dbg_state), 32'(S_WRITE));
        chk("long_wr_hold_grant", 32'(grants()), 32'b010);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        chk("long_wr_done_idle", 32'(o_dbg_state), 32'(S_IDLE));
        chk("long_wr_done_req", 32'(aref_req), 32'd1);
        tick();
        chk("aref_over_read", 32'(o_dbg_state), 32'(S_AREF));
        chk("aref_over_read_grant", 32'(grants()), 32'b100);
        chk("aref_req_clear2", 32'(aref_req), 32'd0);
        chk("overrun_sticky", 32'(aref_overrun), 32'd1);
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        tick();
        chk("read_after_aref", 32'(grants()), 32'b001);

        // Reset mid-READ
        init_end = 1'b0;
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("midrst_state", 32'(o_dbg_state), 32'(S_INIT));
        chk("midrst_grants", 32'(grants()), 32'd0);
        chk("midrst_overrun", 32'(aref_overrun), 32'd0);
        chk("midrst_pins_cmd", 32'(pins_cmd()), 32'h2);
        chk("midrst_pins_addr", 32'(sdram_addr), 32'h0400);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("midrst_no_grant", 32'(grants()), 32'd0);
            chk("midrst_in_init", 32'(o_dbg_state), 32'(S_INIT));
        end
        chk("midrst_no_aref", 32'(aref_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
